// File: rtl/led_blink_counter.sv
// Heartbeat LED: free-running modulo-(CNT_MAX+1) counter toggling led_out on wrap.
// Optional COUNTER_FLAG_EN adds cnt_flag, high during the terminal-count cycle.
module led_blink_counter #(
   parameter int unsigned      CNT_W   = 25,
   parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
`ifdef COUNTER_FLAG_EN
   output logic cnt_flag,
`endif
   output logic led_out
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

   logic [CNT_W-1:0] cnt;
   logic             cnt_wrap;

   assign cnt_wrap = (cnt == CNT_MAX);

   // Compare against CNT_MAX keeps cnt from ever reaching 2^CNT_W.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (cnt_wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         led_out <= 1'b0;
      end else if (cnt_wrap) begin
         led_out <= ~led_out;
      end
   end

`ifdef COUNTER_FLAG_EN
   // Registered one edge early so it lines up with cnt == CNT_MAX.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_flag <= 1'b0;
      end else begin
         cnt_flag <= (cnt == CNT_PRE);
      end
   end
`endif

endmodule

// File: tb/tb_led_blink_counter.sv
// Randomized self-checking bench for led_blink_counter (CNT_MAX = 24 and 1).
// Reference model derives expected outputs from the edge count since release.
module tb_led_blink_counter;

   localparam int W   = 25;
   localparam int P24 = 25;
   localparam int P1  = 2;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   logic led_a;
   logic led_b;
`ifdef COUNTER_FLAG_EN
   logic flag_a;
   logic flag_b;
`endif

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   always #10 sys_clk = ~sys_clk;

   led_blink_counter #(.CNT_W(W), .CNT_MAX(25'd24)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
`ifdef COUNTER_FLAG_EN
      .cnt_flag  (flag_a),
`endif
      .led_out   (led_a)
   );

   led_blink_counter #(.CNT_W(W), .CNT_MAX(25'd1)) dut_min (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
`ifdef COUNTER_FLAG_EN
      .cnt_flag  (flag_b),
`endif
      .led_out   (led_b)
   );

   task automatic check_eq(input string tag, input logic got,
                           input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b k=%0d t=%0t",
                  tag, got, exp, k, $time);
      end
   endtask

   // LED is high during odd-numbered P-edge blocks after release.
   function automatic logic exp_led(input int n, input int p);
      return ((n / p) % 2) == 1;
   endfunction

   // Flag marks the last cycle of each P-edge block.
   function automatic logic exp_flag(input int n, input int p);
      return (n % p) == (p - 1);
   endfunction

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         k++;
         #1;
         check_eq("led24", led_a, exp_led(k, P24));
         check_eq("led1", led_b, exp_led(k, P1));
`ifdef COUNTER_FLAG_EN
         check_eq("flag24", flag_a, exp_flag(k, P24));
         check_eq("flag1", flag_b, exp_flag(k, P1));
`endif
      end
   endtask

   task automatic check_cleared(input string tag);
      check_eq(tag, led_a, 1'b0);
      check_eq(tag, led_b, 1'b0);
`ifdef COUNTER_FLAG_EN
      check_eq(tag, flag_a, 1'b0);
      check_eq(tag, flag_b, 1'b0);
`endif
   endtask

   // Assert reset between edges, hold for some edges, release mid-cycle.
   task automatic pulse_reset(input int hold);
      run_cycles(1);
      #4;
      sys_rst_n = 1'b0;
      #1;
      check_cleared("rst_async");
      if (hold == 0) begin
         #4;
      end else begin
         repeat (hold) begin
            @(posedge sys_clk);
            #1;
            check_cleared("rst_hold");
         end
         #9;
      end
      sys_rst_n = 1'b1;
      k = 0;
   endtask

   initial begin
      #5;
      check_cleared("reset_a");
      #10;
      check_cleared("reset_b");
      #5;
      sys_rst_n = 1'b1;
      k = 0;
      run_cycles(36);
      pulse_reset(1);
      run_cycles(260);
      for (int r = 0; r < 8; r++) begin
         run_cycles(int'($urandom_range(1, 80)));
         pulse_reset(int'($urandom_range(0, 3)));
      end
      run_cycles(60);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_blink_counter.md
Name: led_blink_counter

Overview:
- Free-running modulo-(CNT_MAX+1) cycle counter that toggles a single LED output every time the count wraps.
- Produces a 50% duty-cycle square wave with period 2*(CNT_MAX+1) clock cycles.
- Sits at board top level to drive a status/heartbeat LED from the system clock.
- Default CNT_MAX gives a 0.5 s half-period at 50 MHz.

Parameters:
- CNT_MAX, 25'd24_999_999, terminal count value; the counter runs 0..CNT_MAX inclusive. Legal range 1..2^CNT_W-1. The bench overrides it with 25'd24.
- CNT_W, 25, counter register width in bits; must hold CNT_MAX.

Ports:
- sys_clk  input  1  system clock; all state updates on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- led_out  output  1  LED drive, registered; toggles at each counter wrap.
- cnt_flag  output  1  present only with COUNTER_FLAG_EN; see Optional Feature.

Behaviour:
- Single clock domain (sys_clk). Reset is asynchronous assert, active-low (sys_rst_n).
- Reset values: internal cnt = 0, led_out = 0, cnt_flag = 0. Reset takes effect immediately, without waiting for a clock edge.
- A reset asserted mid-count clears everything immediately; no partial period is remembered.
- Count rule, each rising edge with sys_rst_n = 1:
  - cnt < CNT_MAX: cnt <= cnt + 1.
  - cnt == CNT_MAX: cnt <= 0 (wrap).
- LED rule: led_out inverts on the same rising edge where cnt wraps from CNT_MAX to 0. Otherwise led_out holds.
- Timing after reset release:
  - First led_out rise occurs on the (CNT_MAX+1)-th rising edge after reset deassertion.
  - Thereafter led_out toggles every CNT_MAX+1 edges.
  - Each high phase and each low phase lasts exactly CNT_MAX+1 cycles.
- Arithmetic: unsigned, CNT_W bits. The cnt == CNT_MAX compare guarantees the counter never reaches 2^CNT_W (no natural overflow).
- No enable or load inputs; the counter runs continuously out of reset.
- All outputs come directly from flops (no combinational path from inputs to outputs).

Optional Feature:
- Macro: COUNTER_FLAG_EN.
- Defined:
  - Adds output port cnt_flag (1 bit, registered).
  - cnt_flag is high for exactly one cycle per period: it is registered high on the edge where cnt goes from CNT_MAX-1 to CNT_MAX, and cleared on the next edge.
  - It is therefore asserted during the cycle in which cnt == CNT_MAX, i.e. the cycle immediately before led_out toggles.
  - Resets to 0.
- Not defined:
  - Port and logic are absent.
  - led_out behaviour is identical in both builds.

Test Plan:
- Reset hold: sys_rst_n = 0 for 20 ns with a 20 ns sys_clk -> led_out = 0 throughout; asserting reset between clock edges forces led_out = 0 immediately.
- First toggle, CNT_MAX = 24: release reset -> led_out goes 0->1 on the 25th rising edge after release (500 ns later); no change before that.
- Steady period, CNT_MAX = 24: run 10 full periods -> every high and low phase = 25 cycles (500 ns); LED period = 1000 ns; duty exactly 50%.
- Mid-count reset: pulse sys_rst_n low at cycle 37 for 1 cycle -> led_out = 0 at once; the next toggle lands 25 edges after the new release.
- Minimum terminal count, CNT_MAX = 1: led_out toggles every 2 edges (pattern 0,0,1,1,0,0,...).
- With COUNTER_FLAG_EN, CNT_MAX = 24: cnt_flag is high for exactly 1 cycle, the cycle before each led_out edge; once per 25 cycles; never two consecutive cycles.
